// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcode values, sweep size and
// collector state type.
package alu_pkg;

    localparam int NUM_OPS = 8;
    localparam int IDX_W   = 3;

    localparam logic [IDX_W-1:0] OP_SUM  = 3'd0;
    localparam logic [IDX_W-1:0] OP_RES  = 3'd1;
    localparam logic [IDX_W-1:0] OP_PRO  = 3'd2;
    localparam logic [IDX_W-1:0] OP_AND  = 3'd3;
    localparam logic [IDX_W-1:0] OP_OR   = 3'd4;
    localparam logic [IDX_W-1:0] OP_NAND = 3'd5;
    localparam logic [IDX_W-1:0] OP_NOR  = 3'd6;
    localparam logic [IDX_W-1:0] OP_XOR  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_buf.sv
// Per-opcode result store: one synchronous write port, one asynchronous read
// port, cleared by reset.
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = NUM_OPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write one entry per cycle; reset wipes every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects one ascending opcode sweep of ALU results and flags, flags
// out-of-order opcodes, then drains the entries in opcode order over a
// valid/ready read port.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cap_valid,
    input  logic [2:0]              opcode_in,
    input  logic [2*DATA_WIDTH-1:0] result_in,
    input  logic                    carry_in,
    input  logic                    zero_in,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [2:0]              rd_opcode,
    output logic [2*DATA_WIDTH-1:0] rd_result,
    output logic                    rd_carry,
    output logic                    rd_zero,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    err_order,
    output logic [3:0]              carry_count
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int EW = RW + 2;

    state_t           state;
    logic [IDX_W-1:0] exp_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_idx_nxt;
    logic [IDX_W-1:0] buf_rd_addr;
    logic             wr_en;
    logic [EW-1:0]    buf_rd_data;

    // Accept only the opcode that is next in the ascending sequence.
    always_comb begin
        wr_en = (state == S_CAPTURE) && cap_valid && (opcode_in == exp_idx);
    end

    // The read port looks one entry ahead so the registered rd_* outputs can
    // be loaded with the following entry on the same edge as a transfer;
    // while capturing it points at entry 0 for the first DRAIN cycle.
    always_comb begin
        rd_idx_nxt  = rd_idx + 3'd1;
        buf_rd_addr = (state == S_DRAIN) ? rd_idx_nxt : OP_SUM;
    end

    alu_result_buf #(
        .WIDTH (EW),
        .DEPTH (NUM_OPS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (exp_idx),
        .wr_data ({result_in, carry_in, zero_in}),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    // Sweep FSM with registered outputs: IDLE -> CAPTURE -> DRAIN -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            exp_idx     <= '0;
            rd_idx      <= '0;
            rd_valid    <= 1'b0;
            rd_opcode   <= '0;
            rd_result   <= '0;
            rd_carry    <= 1'b0;
            rd_zero     <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            err_order   <= 1'b0;
            carry_count <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CAPTURE;
                        busy        <= 1'b1;
                        exp_idx     <= '0;
                        err_order   <= 1'b0;
                        carry_count <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (cap_valid) begin
                        if (opcode_in == exp_idx) begin
                            exp_idx     <= exp_idx + 3'd1;
                            carry_count <= carry_count + {3'b000, carry_in};
                            if (exp_idx == OP_XOR) begin
                                state     <= S_DRAIN;
                                rd_idx    <= '0;
                                rd_valid  <= 1'b1;
                                rd_opcode <= OP_SUM;
                                {rd_result, rd_carry, rd_zero} <= buf_rd_data;
                            end
                        end else begin
                            err_order <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rd_ready) begin
                        if (rd_idx == OP_XOR) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            rd_valid   <= 1'b0;
                            sweep_done <= 1'b1;
                        end else begin
                            rd_idx    <= rd_idx_nxt;
                            rd_opcode <= rd_idx_nxt;
                            {rd_result, rd_carry, rd_zero} <= buf_rd_data;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomised self-checking bench for alu_result_collector against a
// behavioural sweep model.
module tb_alu_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cap_valid;
    logic [2:0]  opcode_in;
    logic [15:0] result_in;
    logic        carry_in;
    logic        zero_in;
    logic        rd_ready;
    logic        rd_valid;
    logic [2:0]  rd_opcode;
    logic [15:0] rd_result;
    logic        rd_carry;
    logic        rd_zero;
    logic        busy;
    logic        sweep_done;
    logic        err_order;
    logic [3:0]  carry_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus sequence for one sweep.
    int          s_n;
    logic [2:0]  s_op  [64];
    logic [15:0] s_res [64];
    logic        s_c   [64];
    logic        s_z   [64];

    // Reference model: what the collector should hold for this sweep.
    logic [15:0] m_res [8];
    logic        m_c   [8];
    logic        m_z   [8];
    int          m_exp;
    logic        m_err;
    int          m_cc;

    alu_result_collector #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cap_valid   (cap_valid),
        .opcode_in   (opcode_in),
        .result_in   (result_in),
        .carry_in    (carry_in),
        .zero_in     (zero_in),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_opcode   (rd_opcode),
        .rd_result   (rd_result),
        .rd_carry    (rd_carry),
        .rd_zero     (rd_zero),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .err_order   (err_order),
        .carry_count (carry_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got hang, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        start     = 1'b0;
        cap_valid = 1'b0;
        opcode_in = 3'd0;
        result_in = 16'h0;
        carry_in  = 1'b0;
        zero_in   = 1'b0;
        rd_ready  = 1'b0;
    endtask

    // kind 0: directed A=12,B=16; 1: random in-order; 2: fixed out-of-order;
    // 3: random out-of-order; 4: zero-flag sweep A=0x7F,B=0x81.
    task automatic gen_seq(input int kind);
        logic [15:0] dir_res [8];
        int e;
        dir_res[0] = 16'h001C; dir_res[1] = 16'h01FC; dir_res[2] = 16'h00C0;
        dir_res[3] = 16'h0000; dir_res[4] = 16'h001C; dir_res[5] = 16'h00FF;
        dir_res[6] = 16'h00E3; dir_res[7] = 16'h001C;
        s_n = 0;
        e   = 0;
        if (kind == 2) begin
            for (int i = 0; i < 9; i++) begin
                s_op[i]  = (i < 2) ? 3'(i) : (i == 2) ? 3'd3 : (i == 3) ? 3'd2 : 3'(i - 1);
                s_res[i] = 16'($urandom);
                s_c[i]   = 1'($urandom);
                s_z[i]   = 1'($urandom);
            end
            s_n = 9;
        end else begin
            while (e < 8) begin
                if ((kind == 3) && (s_n < 48) && ($urandom_range(0, 3) == 0))
                    s_op[s_n] = 3'($urandom_range(0, 7));
                else
                    s_op[s_n] = 3'(e);
                s_res[s_n] = 16'($urandom);
                s_c[s_n]   = 1'($urandom);
                s_z[s_n]   = 1'($urandom);
                if (kind == 0) begin
                    s_res[s_n] = dir_res[e];
                    s_c[s_n]   = (e == 1);
                    s_z[s_n]   = (dir_res[e] == 16'h0);
                end
                if ((kind == 4) && (e == 0)) begin
                    s_res[s_n] = 16'h0100;
                    s_c[s_n]   = 1'b1;
                    s_z[s_n]   = 1'b1;
                end
                if (int'(s_op[s_n]) == e) e++;
                s_n++;
            end
        end
    endtask

    task automatic start_sweep;
        start     = 1'b1;
        cap_valid = 1'b1;
        opcode_in = 3'd0;
        tick();
        start     = 1'b0;
        cap_valid = 1'b0;
        m_exp = 0;
        m_err = 1'b0;
        m_cc  = 0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_err_clr", 32'(err_order), 32'd0);
        check_eq("start_cc_clr", 32'(carry_count), 32'd0);
    endtask

    // Feed the first n items of the sequence, with random gaps and a stray start.
    task automatic capture_phase(input int n);
        for (int i = 0; i < n; i++) begin
            cap_valid = 1'b1;
            opcode_in = s_op[i];
            result_in = s_res[i];
            carry_in  = s_c[i];
            zero_in   = s_z[i];
            start     = (i == 2);
            if (int'(s_op[i]) == m_exp) begin
                m_res[m_exp] = s_res[i];
                m_c[m_exp]   = s_c[i];
                m_z[m_exp]   = s_z[i];
                m_cc += int'(s_c[i]);
                m_exp++;
            end else begin
                m_err = 1'b1;
            end
            tick();
            idle_inputs();
            check_eq("cap_err", 32'(err_order), 32'(m_err));
            check_eq("cap_cc", 32'(carry_count), 32'(m_cc));
            check_eq("cap_busy", 32'(busy), 32'd1);
            check_eq("cap_rd_valid", 32'(rd_valid), (m_exp == 8) ? 32'd1 : 32'd0);
            if ((m_exp < 8) && ($urandom_range(0, 3) == 0)) begin
                opcode_in = 3'($urandom);
                tick();
            end
        end
    endtask

    // rmode 0: ready always; 1: pattern 0,0,1; 2: random.
    task automatic drain_phase(input int rmode);
        int idx = 0;
        int cyc = 0;
        while ((idx < 8) && (cyc < 200)) begin
            check_eq("rd_valid", 32'(rd_valid), 32'd1);
            check_eq("rd_opcode", 32'(rd_opcode), 32'(idx));
            check_eq("rd_result", 32'(rd_result), 32'(m_res[idx]));
            check_eq("rd_carry", 32'(rd_carry), 32'(m_c[idx]));
            check_eq("rd_zero", 32'(rd_zero), 32'(m_z[idx]));
            check_eq("drain_done_low", 32'(sweep_done), 32'd0);
            rd_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 2) : 1'($urandom);
            cap_valid = 1'($urandom);
            opcode_in = 3'($urandom);
            result_in = 16'($urandom);
            start     = 1'($urandom);
            tick();
            if (rd_ready) idx++;
            cyc++;
        end
        idle_inputs();
        check_eq("drain_count", 32'(idx), 32'd8);
        check_eq("done_pulse", 32'(sweep_done), 32'd1);
        check_eq("done_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_err", 32'(err_order), 32'(m_err));
        check_eq("done_cc", 32'(carry_count), 32'(m_cc));
        cap_valid = 1'b1;
        opcode_in = 3'd0;
        tick();
        idle_inputs();
        check_eq("done_one_cycle", 32'(sweep_done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("hold_err", 32'(err_order), 32'(m_err));
        check_eq("hold_cc", 32'(carry_count), 32'(m_cc));
    endtask

    task automatic full_sweep(input int kind, input int rmode);
        gen_seq(kind);
        start_sweep();
        capture_phase(s_n);
        drain_phase(rmode);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_cc", 32'(carry_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // cap_valid in IDLE must not start anything
        cap_valid = 1'b1;
        repeat (3) tick();
        idle_inputs();
        check_eq("idle_ignore_busy", 32'(busy), 32'd0);
        check_eq("idle_ignore_valid", 32'(rd_valid), 32'd0);

        full_sweep(0, 0);
        check_eq("dir_cc", 32'(carry_count), 32'd1);
        check_eq("dir_err", 32'(err_order), 32'd0);
        full_sweep(0, 1);
        full_sweep(2, 0);
        check_eq("ooo_err", 32'(err_order), 32'd1);
        full_sweep(4, 2);

        // reset after five captures, then a fresh sweep
        gen_seq(1);
        start_sweep();
        capture_phase(5);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_cc", 32'(carry_count), 32'd0);
        check_eq("mid_rst_err", 32'(err_order), 32'd0);
        check_eq("mid_rst_valid", 32'(rd_valid), 32'd0);
        check_eq("mid_rst_result", 32'(rd_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        full_sweep(1, 2);

        for (int r = 0; r < 12; r++) begin
            full_sweep((r % 2 == 0) ? 3 : 1, r % 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Receiving end of the ALU result interface.
- Captures one full opcode sweep (opcodes 0..7) of ALU result and flags into an 8-entry buffer.
- Checks that the opcodes arrive in ascending order.
- Drains the buffer in opcode order over a valid/ready read port to a downstream consumer (logger, display or UART).
- Sits beside top_moduleAlu and is fed by its out/flag outputs.

Parameters:
- DATA_WIDTH, 8, operand width of the ALU. Result width is 2*DATA_WIDTH.
- NUM_OPS, 8, entries per sweep. Fixed at 2**3 to match the 3-bit opcode.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  arms a new sweep capture; single-cycle pulse
- cap_valid  in  1  ALU result for opcode_in is valid this cycle
- opcode_in  in  3  opcode that produced result_in
- result_in  in  2*DATA_WIDTH  ALU out value
- carry_in  in  1  ALU carry flag
- zero_in  in  1  ALU zero flag
- rd_ready  in  1  consumer accepts the current read entry
- rd_valid  out  1  read entry valid
- rd_opcode  out  3  opcode of the read entry
- rd_result  out  2*DATA_WIDTH  stored result
- rd_carry  out  1  stored carry flag
- rd_zero  out  1  stored zero flag
- busy  out  1  high in CAPTURE or DRAIN
- sweep_done  out  1  one-cycle pulse when the last entry is accepted
- err_order  out  1  sticky; an out-of-order opcode was seen in this sweep
- carry_count  out  4  number of stored entries with carry=1 in the current sweep

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; expected index goes to 0.
  - All buffer entries, all outputs and carry_count go to 0.
  - Reset mid-sweep discards everything.
- States: IDLE, CAPTURE, DRAIN. Encoding is registered; all outputs are registered.
- IDLE:
  - cap_valid is ignored.
  - start=1 -> CAPTURE next edge; clears err_order and carry_count; exp_idx=0.
- CAPTURE:
  - On an edge with cap_valid=1 and opcode_in==exp_idx: store {result_in, carry_in, zero_in} in entry[exp_idx]; exp_idx+1; carry_count += carry_in.
  - On cap_valid=1 and opcode_in!=exp_idx: entry is not stored, err_order<=1 (sticky), exp_idx unchanged.
  - When entry 7 is stored: DRAIN next edge, rd_idx=0.
- DRAIN:
  - rd_valid=1 from the first DRAIN cycle.
  - rd_* present entry[rd_idx] and stay stable while rd_ready=0.
  - A transfer occurs on an edge with rd_valid & rd_ready; it increments rd_idx.
  - Back-to-back transfers are allowed: 1 entry/cycle with rd_ready held high.
  - Transfer of entry 7: rd_valid<=0, sweep_done<=1 for one cycle, state -> IDLE.
- start is ignored in CAPTURE and DRAIN. cap_valid is ignored in DRAIN.
- Latency: last capture edge to rd_valid=1 is 1 cycle. Minimum start-to-sweep_done is 1 + 8 + 8 cycles.
- err_order and carry_count hold after sweep_done until the next start.
- carry_count saturates at 8 by construction; the width is 4 bits.
- busy = (state != IDLE).

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_SUM=0, OP_RES=1, OP_PRO=2, OP_AND=3, OP_OR=4, OP_NAND=5, OP_NOR=6, OP_XOR=7
  - state encodings S_IDLE, S_CAPTURE, S_DRAIN
  - NUM_OPS
- One sub-module: alu_result_buf, an 8 x (2*DATA_WIDTH+2) register file with one write port and one async read port.
- The FSM, counters and checks stay in the top module.

Test Plan:
- In-order sweep, A=12 and B=16.
  - Stimulus: start, then cap_valid for ops 0..7 with results 0x001C, 0x01FC, 0x00C0, 0x0000, 0x001C, 0x00FF, 0x00E3, 0x001C; carry set on op1 only; rd_ready=1.
  - Response: rd entries 0..7 in order with those values; carry_count=1; err_order=0; sweep_done pulses one cycle after entry 7.
- Backpressure.
  - Stimulus: same sweep; rd_ready toggles 0,0,1 repeating.
  - Response: rd_* stable while stalled; each entry delivered exactly once; sweep_done after 8 accepts.
- Out-of-order opcode.
  - Stimulus: ops 0,1,3,2,3..7.
  - Response: op3 at the third position is dropped; err_order=1 from the next edge; 8 entries still drained; err_order stays 1 until the next start.
- Ignored inputs.
  - Stimulus: cap_valid in IDLE; start in CAPTURE; cap_valid in DRAIN.
  - Response: no state change, entries unaffected, busy unchanged.
- Reset mid-operation.
  - Stimulus: rst_n=0 asynchronously after 5 captures, then a new full sweep.
  - Response: outputs 0 immediately; new sweep delivers only the new values; carry_count counts only the new sweep.
- Zero flag.
  - Stimulus: sweep with A=127 and B=-127 (0x7F, 0x81); op0 result 0x0100 with zero_in=1, carry_in=1.
  - Response: rd_zero=1 and rd_carry=1 on entry 0.
